// File: rtl/core_mem_arb_pkg.sv
// Shared types for the core memory arbiter: requester IDs and FSM states.
package core_mem_arb_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } arb_state_e;

    // The requester that is not `id`; used to hand priority across after a grant.
    function automatic req_id_e other_id(req_id_e id);
        return (id == REQ_DATA) ? REQ_INSTR : REQ_DATA;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bus bundle for core_mem_arbiter: fetch port, data port, memory port, error flag.
// slave = arbiter view, master = core/memory environment view.
interface core_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    instr_req_i;
    logic                    instr_gnt_o;
    logic                    instr_rvalid_o;
    logic [ADDR_WIDTH-1:0]   instr_addr_i;
    logic [DATA_WIDTH-1:0]   instr_rdata_o;

    logic                    data_req_i;
    logic                    data_gnt_o;
    logic                    data_rvalid_o;
    logic                    data_we_i;
    logic [DATA_WIDTH/8-1:0] data_be_i;
    logic [ADDR_WIDTH-1:0]   data_addr_i;
    logic [DATA_WIDTH-1:0]   data_wdata_i;
    logic [DATA_WIDTH-1:0]   data_rdata_o;

    logic                    mem_req_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic                    mem_we_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    logic                    err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/core_mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Push and pop in the same cycle is legal even when full (count unchanged).
module core_mem_arb_id_fifo
    import core_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push,
    input  req_id_e push_id,
    input  logic    pop,
    output req_id_e head_id,
    output logic    full,
    output logic    empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    req_id_e       slots [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = slots[rd_ptr];

    // Pointer, occupancy and storage update; everything cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= REQ_INSTR;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_id;
                wr_ptr        <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/core_mem_arbiter.sv
// Fetch/data arbiter in front of a single-ported req/gnt/rvalid memory.
// Define CORE_MEM_ARB_RR_EN for round-robin; otherwise data beats instruction.
module core_mem_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    core_mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    req_id_e    lock_q, lock_d, sel_id, winner, head_id;
    logic       mem_req, push, pop, full, empty, err_q, err_set;
    logic       any_req, slot_free, lock_req, is_data;

    logic [ADDR_WIDTH-1:0] fwd_addr;
    logic [DATA_WIDTH-1:0] fwd_wdata;
    logic [BE_W-1:0]       fwd_be;

    // Reset gates the request path so outputs drop immediately on rst_ni.
    assign any_req   = rst_ni && (bus.instr_req_i || bus.data_req_i);
    assign pop       = bus.mem_rvalid_i && !empty;
    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign slot_free = !full || pop;
    assign lock_req  = (lock_q == REQ_DATA) ? bus.data_req_i : bus.instr_req_i;

`ifdef CORE_MEM_ARB_RR_EN
    req_id_e prio_q;

    // The requester not granted last gets priority on the next contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   prio_q <= REQ_DATA;
        else if (push) prio_q <= other_id(sel_id);
    end

    assign winner = (bus.instr_req_i && bus.data_req_i) ? prio_q :
                    (bus.data_req_i ? REQ_DATA : REQ_INSTR);
`else
    assign winner = bus.data_req_i ? REQ_DATA : REQ_INSTR;
`endif

    // Next-state, selection and error detection.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        sel_id  = winner;
        mem_req = 1'b0;
        push    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && slot_free) begin
                    mem_req = 1'b1;
                    if (bus.mem_gnt_i) begin
                        push = 1'b1;
                    end else begin
                        state_d = WAIT_GNT;
                        lock_d  = winner;
                    end
                end
            end
            WAIT_GNT: begin
                sel_id = lock_q;
                if (lock_req) begin
                    mem_req = 1'b1;
                    if (bus.mem_gnt_i) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    // Locked requester withdrew before its grant.
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.mem_rvalid_i && empty) err_set = 1'b1;
    end

    // FSM state, locked requester and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= REQ_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            err_q   <= err_q | err_set;
        end
    end

    core_mem_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push),
        .push_id (sel_id),
        .pop     (pop),
        .head_id (head_id),
        .full    (full),
        .empty   (empty)
    );

    // Forwarded request: fetches are full-word reads; idle bus drives zeros.
    assign is_data   = (sel_id == REQ_DATA);
    assign fwd_addr  = !mem_req ? '0 : (is_data ? bus.data_addr_i  : bus.instr_addr_i);
    assign fwd_wdata = !mem_req ? '0 : (is_data ? bus.data_wdata_i : '0);
    assign fwd_be    = !mem_req ? '0 : (is_data ? bus.data_be_i    : '1);

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_req && is_data && bus.data_we_i;
    assign bus.mem_addr_o  = fwd_addr;
    assign bus.mem_wdata_o = fwd_wdata;
    assign bus.mem_be_o    = fwd_be;

    assign bus.instr_gnt_o = bus.mem_gnt_i && mem_req && !is_data;
    assign bus.data_gnt_o  = bus.mem_gnt_i && mem_req && is_data;

    assign bus.instr_rvalid_o = pop && (head_id == REQ_INSTR);
    assign bus.data_rvalid_o  = pop && (head_id == REQ_DATA);
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;

    assign bus.err_o = err_q;
endmodule
